// File: rtl/ram_word_master.sv
// Word-level initiator for the nibble-wide RAM: each accepted host request
// becomes WORD_NIBBLES consecutive single-nibble accesses, most-significant nibble first.
module ram_word_master #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 4,
  parameter int WORD_NIBBLES = 4,
  localparam int WORD_W = DATA_WIDTH * WORD_NIBBLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reqValid_i,
  output logic                  reqReady_o,
  input  logic                  reqWrite_i,
  input  logic [ADDR_WIDTH-1:0] reqAddr_i,
  input  logic [WORD_W-1:0]     reqData_i,
  output logic                  rspValid_o,
  input  logic                  rspReady_i,
  output logic [WORD_W-1:0]     rspData_o,
  output logic                  ramWriteEn_o,
  output logic                  ramReadEn_o,
  output logic [ADDR_WIDTH-1:0] ramAddr_o,
  output logic [DATA_WIDTH-1:0] ramDIn_o,
  input  logic [DATA_WIDTH-1:0] ramDOut_i
);

  localparam int CNT_W = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [DATA_WIDTH-1:0]   nib_in;
  logic [WORD_W+DATA_WIDTH-1:0] shifted;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  // One shift register serves both directions: writes drain from the top,
  // reads fill from the bottom. Writes shift in zeros, so the word reads 0 in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    word_d       = word_q;
    reqReady_o   = 1'b0;
    rspValid_o   = 1'b0;
    rspData_o    = '0;
    ramWriteEn_o = 1'b0;
    ramReadEn_o  = 1'b0;
    ramAddr_o    = '0;
    ramDIn_o     = '0;
    nib_in       = write_q ? '0 : ramDOut_i;
    shifted      = {word_q, nib_in};
    case (state_q)
      IDLE: begin
        reqReady_o = 1'b1;
        if (reqValid_i) begin
          write_d = reqWrite_i;
          addr_d  = reqAddr_i;
          word_d  = reqData_i;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        ramAddr_o = addr_q + ADDR_WIDTH'(cnt_q);
        if (write_q) begin
          ramWriteEn_o = 1'b1;
          ramDIn_o     = word_q[WORD_W-1 -: DATA_WIDTH];
        end else begin
          ramReadEn_o  = 1'b1;
        end
        word_d = shifted[WORD_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WORD_NIBBLES-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        rspValid_o = 1'b1;
        rspData_o  = word_q;
        if (rspReady_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_word_master.sv
// Bench for ram_word_master: behavioural nibble RAM, shadow-memory scoreboard
// of expected responses, one task per scenario.
module tb_ram_word_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0;
  logic [11:0] reqAddr = '0;
  logic [15:0] reqData = '0;
  logic        rspValid, rspReady = 1'b1;
  logic [15:0] rspData;
  logic        ramWriteEn, ramReadEn;
  logic [11:0] ramAddr;
  logic [3:0]  ramDIn, ramDOut;

  logic [3:0]  mem    [0:4095];
  logic [3:0]  shadow [0:4095];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_word_master dut (
    .clk_i(clk), .rst_i(rst),
    .reqValid_i(reqValid), .reqReady_o(reqReady), .reqWrite_i(reqWrite),
    .reqAddr_i(reqAddr), .reqData_i(reqData),
    .rspValid_o(rspValid), .rspReady_i(rspReady), .rspData_o(rspData),
    .ramWriteEn_o(ramWriteEn), .ramReadEn_o(ramReadEn),
    .ramAddr_o(ramAddr), .ramDIn_o(ramDIn), .ramDOut_i(ramDOut)
  );

  assign ramDOut = mem[ramAddr];
  always @(posedge clk) if (ramWriteEn) mem[ramAddr] <= ramDIn;

  // Drive one request, push its expected response, observe strobes until rspValid.
  task automatic run_xfer(input logic w, input logic [11:0] a, input logic [15:0] d,
                          output int wen, output int ren, output int lat,
                          output logic [15:0] rsp, output bit addr_ok);
    logic [15:0] e;
    logic [11:0] ai;
    int n, k;
    wen = 0; ren = 0; lat = 0; rsp = '0; addr_ok = 1'b1; e = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 12'(i);
      if (w) shadow[ai] = d[15-4*i -: 4];
      else   e = {e[11:0], shadow[ai]};
    end
    exp_q.push_back(e);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d;
    n = 0;
    while (reqReady !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
    lat = 1;
    while (rspValid !== 1'b1 && lat < 20) begin
      k = wen + ren;
      if (ramWriteEn === 1'b1 && ramReadEn === 1'b1) addr_ok = 1'b0;
      if (ramWriteEn === 1'b1 || ramReadEn === 1'b1) begin
        ai = a + 12'(k);
        if (ramAddr !== ai) addr_ok = 1'b0;
        if (w && k < 4 && ramDIn !== d[15-4*k -: 4]) addr_ok = 1'b0;
      end else if (ramAddr !== 12'h0 || ramDIn !== 4'h0) addr_ok = 1'b0;
      wen += int'(ramWriteEn);
      ren += int'(ramReadEn);
      @(negedge clk);
      lat++;
    end
    rsp = rspData;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady: got %b exp 1", reqReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_rspValid: got %b exp 0", rspValid); end
    checks++; if (rspData !== 16'h0) begin errors++; $display("FAIL reset_rspData: got %h exp 0", rspData); end
    checks++; if ({ramWriteEn, ramReadEn} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b exp 00", {ramWriteEn, ramReadEn}); end
    checks++; if ({ramAddr, ramDIn} !== 16'h0) begin errors++; $display("FAIL reset_ramAddrDin: got %h exp 0", {ramAddr, ramDIn}); end
    rst = 1'b0;
  endtask

  task automatic test_write;
    int wen, ren, lat; logic [15:0] rsp, e; bit ok;
    logic [15:0] word;
    word = 16'hBEEF;
    run_xfer(1'b1, 12'h100, word, wen, ren, lat, rsp, ok);
    e = exp_q.pop_front();
    checks++; if (wen !== 4 || ren !== 0) begin errors++; $display("FAIL write_strobes: got wen=%0d ren=%0d exp 4/0", wen, ren); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL write_latency: got %0d exp 5", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_addr_din: got %b exp 1", ok); end
    checks++; if (rsp !== e) begin errors++; $display("FAIL write_rspData: got %h exp %h", rsp, e); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12'h100 + 12'(i)] !== word[15-4*i -: 4]) begin
        errors++; $display("FAIL write_mem%0d: got %h exp %h", i, mem[12'h100 + 12'(i)], word[15-4*i -: 4]);
      end
    end
  endtask

  task automatic test_read;
    int wen, ren, lat; logic [15:0] rsp, e; bit ok;
    run_xfer(1'b0, 12'h100, 16'h0, wen, ren, lat, rsp, ok);
    e = exp_q.pop_front();
    checks++; if (ren !== 4 || wen !== 0) begin errors++; $display("FAIL read_strobes: got wen=%0d ren=%0d exp 0/4", wen, ren); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL read_latency: got %0d exp 5", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_addr: got %b exp 1", ok); end
    checks++; if (rsp !== e) begin errors++; $display("FAIL read_rspData: got %h exp %h", rsp, e); end
    checks++; if (rsp !== 16'hBEEF) begin errors++; $display("FAIL read_beef: got %h exp beef", rsp); end
  endtask

  task automatic test_wrap;
    int wen, ren, lat; logic [15:0] rsp, e; bit ok;
    run_xfer(1'b1, 12'hFFE, 16'h1234, wen, ren, lat, rsp, ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || wen !== 4) begin errors++; $display("FAIL wrap_write: got ok=%b wen=%0d exp 1/4", ok, wen); end
    checks++; if (rsp !== e) begin errors++; $display("FAIL wrap_write_rsp: got %h exp %h", rsp, e); end
    checks++;
    if ({mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]} !== 16'h1234) begin
      errors++; $display("FAIL wrap_mem: got %h%h%h%h exp 1234", mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]);
    end
    run_xfer(1'b0, 12'hFFE, 16'h0, wen, ren, lat, rsp, ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || ren !== 4) begin errors++; $display("FAIL wrap_read: got ok=%b ren=%0d exp 1/4", ok, ren); end
    checks++; if (rsp !== e) begin errors++; $display("FAIL wrap_read_rsp: got %h exp %h", rsp, e); end
  endtask

  task automatic test_backpressure;
    int wen, ren, lat, n; logic [15:0] rsp, held, e; bit ok;
    rspReady = 1'b0;
    run_xfer(1'b0, 12'hFFE, 16'h0, wen, ren, lat, rsp, ok);
    held = rsp;
    e = exp_q.pop_front();
    checks++; if (held !== e) begin errors++; $display("FAIL bp_rspData: got %h exp %h", held, e); end
    exp_q.push_back({shadow[12'h100], shadow[12'h101], shadow[12'h102], shadow[12'h103]});
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 12'h100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rspValid !== 1'b1 || rspData !== held || reqReady !== 1'b0 || ramReadEn !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b ren=%b exp 1/%h/0/0", i, rspValid, rspData, reqReady, ramReadEn, held);
      end
    end
    rspReady = 1'b1;
    @(negedge clk);
    checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b exp 0/1", rspValid, reqReady); end
    @(negedge clk);
    reqValid = 1'b0; reqAddr = '0;
    checks++;
    if (reqReady !== 1'b0 || ramReadEn !== 1'b1 || ramAddr !== 12'h100) begin
      errors++; $display("FAIL bp_pending_accept: got rdy=%b ren=%b addr=%h exp 0/1/100", reqReady, ramReadEn, ramAddr);
    end
    n = 0;
    while (rspValid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL bp_pending_timeout: got %b exp 1", rspValid); end
    checks++; if (rspData !== e) begin errors++; $display("FAIL bp_pending_rsp: got %h exp %h", rspData, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL rm_ready_before: got %b exp 1", reqReady); end
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 12'h200; reqData = 16'hA5C3;
    @(negedge clk);
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
    checks++; if (ramWriteEn !== 1'b1) begin errors++; $display("FAIL rm_first_nibble: got %b exp 1", ramWriteEn); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ramWriteEn !== 1'b0 || reqReady !== 1'b1 || rspValid !== 1'b0) begin
      errors++; $display("FAIL rm_after_reset: got wen=%b rdy=%b v=%b exp 0/1/0", ramWriteEn, reqReady, rspValid);
    end
    rst = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); seen += int'(rspValid) + int'(ramWriteEn); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_response: got %0d exp 0", seen); end
    checks++;
    if ({mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]} !== 16'hA500) begin
      errors++; $display("FAIL rm_mem: got %h%h%h%h exp a500", mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; shadow[i] = '0; end
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
